// File: rtl/clmul8_arbiter_if.sv
// Request/response bundle for the two-port carry-less multiplier arbiter.
// Accumulate-select inputs exist only when CLMUL8_ARB_ACC_EN is defined.
interface clmul8_arbiter_if;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_y, rsp1_y;
`ifdef CLMUL8_ARB_ACC_EN
  logic       req0_acc, req1_acc;
`endif

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
`ifdef CLMUL8_ARB_ACC_EN
    output req0_acc, req1_acc,
`endif
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_y, rsp1_y
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
`ifdef CLMUL8_ARB_ACC_EN
    input  req0_acc, req1_acc,
`endif
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_y, rsp1_y
  );
endinterface

// File: rtl/clmul8_arbiter.sv
// Two-port arbiter around one 8-bit truncated carry-less multiplier; result valid 1 cycle after accept.
// Pending result stalls new accepts until consumed; CLMUL8_ARB_ACC_EN adds per-port XOR accumulators.
module clmul8_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  clmul8_arbiter_if.slave bus,
  output logic            busy
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t     state, state_nxt;
  logic [7:0] result, result_nxt;
  logic       gnt, gnt_nxt, last, last_nxt;
  logic       rsp_hs, slot_free, accept, win;
  logic [7:0] win_a, win_b, prod;

  function automatic logic [7:0] clmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++)
      if (b[i]) y = y ^ (a << i);
    return y;
  endfunction

`ifdef CLMUL8_ARB_ACC_EN
  logic [7:0] acc0, acc1;
  logic       win_acc;
`endif

  always_comb begin
    rsp_hs     = 1'b0;
    slot_free  = 1'b0;
    win        = 1'b0;
    accept     = 1'b0;
    win_a      = 8'h00;
    win_b      = 8'h00;
    prod       = 8'h00;
    result_nxt = result;
    gnt_nxt    = gnt;
    last_nxt   = last;
    state_nxt  = state;

    rsp_hs    = (state == RESP) && (gnt ? bus.rsp1_ready : bus.rsp0_ready);
    slot_free = (state == IDLE) || rsp_hs;
    if (bus.req0_valid && bus.req1_valid)
      win = (PRIO_FIXED != 0) ? 1'b0 : ~last;
    else
      win = bus.req1_valid;
    // rst_n gate keeps ready low while reset holds the FSM in IDLE
    accept = rst_n && slot_free && (bus.req0_valid || bus.req1_valid);

    win_a = win ? bus.req1_a : bus.req0_a;
    win_b = win ? bus.req1_b : bus.req0_b;
    prod  = clmul8(win_a, win_b);

    if (accept) begin
`ifdef CLMUL8_ARB_ACC_EN
      result_nxt = prod ^ (win_acc ? (win ? acc1 : acc0) : 8'h00);
`else
      result_nxt = prod;
`endif
      gnt_nxt   = win;
      last_nxt  = win;
      state_nxt = RESP;
    end else if (rsp_hs) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= 8'h00;
      gnt    <= 1'b0;
      last   <= 1'b1;
    end else begin
      state  <= state_nxt;
      result <= result_nxt;
      gnt    <= gnt_nxt;
      last   <= last_nxt;
    end
  end

`ifdef CLMUL8_ARB_ACC_EN
  assign win_acc = win ? bus.req1_acc : bus.req0_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0 <= 8'h00;
      acc1 <= 8'h00;
    end else if (accept) begin
      if (win) acc1 <= result_nxt;
      else     acc0 <= result_nxt;
    end
  end
`endif

  assign bus.req0_ready = accept && !win;
  assign bus.req1_ready = accept && win;
  assign bus.rsp0_valid = (state == RESP) && !gnt;
  assign bus.rsp1_valid = (state == RESP) && gnt;
  assign bus.rsp0_y     = result;
  assign bus.rsp1_y     = result;
  assign busy           = (state == RESP);
endmodule
